// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic other_owner(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational gnt, prio flips to the loser on every grant.
// Zero latency; a requester simply keeps req high until it sees gnt.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req[0] && (!req[1] || prio == M0))
        gnt[0] = 1'b1;
      else if (req[1])
        gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      prio <= M0;
    else if (gnt[0])
      prio <= other_owner(M0);
    else if (gnt[1])
      prio <= other_owner(M1);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the 32x32 data memory between m0 and m1, one access per cycle.
// Grant in G, memory cycle G+1, read data + rvalid in G+2; losers hold req until gnt.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_worr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_worr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_ena,
  output logic              mem_worr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              win;
  logic              cmd_owner;
  logic              cmd_worr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign any_gnt = |gnt;
  assign win     = gnt[1] ? M1 : M0;

  // Memory pins are decoded straight from registers, so they are glitch-free.
  assign mem_ena   = (state == ACCESS);
  assign mem_worr  = (state == ACCESS) && cmd_worr;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_owner <= M0;
      cmd_worr  <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state     <= any_gnt ? ACCESS : IDLE;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;

      if (any_gnt) begin
        cmd_owner <= win;
        cmd_worr  <= (win == M1) ? m1_worr  : m0_worr;
        cmd_addr  <= (win == M1) ? m1_addr  : m0_addr;
        cmd_wdata <= (win == M1) ? m1_wdata : m0_wdata;
      end

      // mem_rdata is only driven while a read is enabled.
      if (state == ACCESS && !cmd_worr) begin
        if (cmd_owner == M1) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= mem_rdata;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32x32 memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_worr, m1_req, m1_worr;
  logic [4:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ena, mem_worr;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  wire  [31:0] mem_rdata;

  logic [31:0] mem [32];
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_dat;

  int n_pass;
  int n_fail;
  int n_total;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_worr   (m0_worr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_worr   (m1_worr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_ena   (mem_ena),
    .mem_worr  (mem_worr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_dat;
    else if (mem_ena && mem_worr)
      mem[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = (mem_ena && !mem_worr) ? mem[mem_addr] : 32'hzzzz_zzzz;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst = 1'b1;
    m0_req = 0; m0_worr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_worr = 0; m1_addr = 0; m1_wdata = 0;
    pre_we = 1'b1; pre_addr = 5'd0; pre_dat = 32'hA0;

    // Reset state and memory preload.
    mid();
    check1 ("rst mem_ena",   mem_ena,   1'b0);
    check1 ("rst mem_worr",  mem_worr,  1'b0);
    check32("rst mem_addr",  {27'b0, mem_addr}, 32'h0);
    check32("rst mem_wdata", mem_wdata, 32'h0);
    check1 ("rst m0_rvalid", m0_rvalid, 1'b0);
    check1 ("rst m1_rvalid", m1_rvalid, 1'b0);
    check32("rst m0_rdata",  m0_rdata,  32'h0);
    check32("rst m1_rdata",  m1_rdata,  32'h0);
    check1 ("rst m0_gnt",    m0_gnt,    1'b0);
    check1 ("rst m1_gnt",    m1_gnt,    1'b0);
    nxt(); pre_addr = 5'd1; pre_dat = 32'hA1;
    nxt(); pre_addr = 5'd2; pre_dat = 32'hA2;
    nxt(); pre_we = 1'b0;
    rst = 1'b0;
    nxt();

    // Reset in the middle of an m0 read of addr 3.
    m0_req = 1; m0_worr = 0; m0_addr = 5'd3;
    mid();
    check1("r3 m0_gnt", m0_gnt, 1'b1);
    check1("r3 m1_gnt", m1_gnt, 1'b0);
    nxt(); m0_req = 0;
    mid();
    check1 ("r3 access mem_ena", mem_ena, 1'b1);
    check32("r3 access mem_addr", {27'b0, mem_addr}, 32'd3);
    rst = 1'b1;
    #1;
    check1("async rst mem_ena", mem_ena, 1'b0);
    check1("async rst prio", dut.u_arb.prio, 1'b0);
    nxt();
    rst = 1'b0;
    m0_req = 1; m0_worr = 0; m0_addr = 5'd0;
    m1_req = 1; m1_worr = 0; m1_addr = 5'd1;
    mid();
    check1 ("post-rst no m0_rvalid", m0_rvalid, 1'b0);
    check32("post-rst m0_rdata", m0_rdata, 32'h0);
    check1 ("post-rst m0_gnt first", m0_gnt, 1'b1);
    check1 ("post-rst m1_gnt wait",  m1_gnt, 1'b0);
    nxt(); m0_req = 0;
    mid();
    check1("post-rst m1_gnt", m1_gnt, 1'b1);
    check1("post-rst m0_gnt low", m0_gnt, 1'b0);
    nxt(); m1_req = 0;
    mid();
    check1 ("post-rst m0_rvalid", m0_rvalid, 1'b1);
    check32("post-rst m0_rdata A0", m0_rdata, 32'hA0);
    nxt();
    mid();
    check1 ("post-rst m1_rvalid", m1_rvalid, 1'b1);
    check32("post-rst m1_rdata A1", m1_rdata, 32'hA1);
    check1 ("post-rst m0_rvalid one-shot", m0_rvalid, 1'b0);
    nxt();

    // Contention: both hold req for six cycles.
    m0_req = 1; m0_worr = 0; m0_addr = 5'd0;
    m1_req = 1; m1_worr = 0; m1_addr = 5'd1;
    for (int i = 0; i < 6; i++) begin
      mid();
      check1("contend m0_gnt", m0_gnt, (i % 2) == 0);
      check1("contend m1_gnt", m1_gnt, (i % 2) == 1);
      nxt();
    end
    m0_req = 0; m1_req = 0;
    nxt(); nxt(); nxt();

    // m0 write addr 5 then read it back.
    m0_req = 1; m0_worr = 1; m0_addr = 5'd5; m0_wdata = 32'hDEADBEEF;
    mid();
    check1("wr5 gnt", m0_gnt, 1'b1);
    check1("wr5 G mem_ena", mem_ena, 1'b0);
    nxt(); m0_worr = 0;
    mid();
    check1 ("rd5 gnt", m0_gnt, 1'b1);
    check1 ("wr5 mem_ena", mem_ena, 1'b1);
    check1 ("wr5 mem_worr", mem_worr, 1'b1);
    check32("wr5 mem_addr", {27'b0, mem_addr}, 32'd5);
    check32("wr5 mem_wdata", mem_wdata, 32'hDEADBEEF);
    nxt(); m0_req = 0;
    mid();
    check1("rd5 mem_ena", mem_ena, 1'b1);
    check1("rd5 mem_worr", mem_worr, 1'b0);
    check1("wr5 no rvalid", m0_rvalid, 1'b0);
    nxt();
    mid();
    check1 ("rd5 m0_rvalid", m0_rvalid, 1'b1);
    check32("rd5 m0_rdata", m0_rdata, 32'hDEADBEEF);
    check1 ("rd5 idle mem_ena", mem_ena, 1'b0);
    nxt();
    mid();
    check1("rd5 rvalid one-shot", m0_rvalid, 1'b0);
    nxt();

    // m1 writes addr 31, m0 reads it the next cycle.
    m1_req = 1; m1_worr = 1; m1_addr = 5'd31; m1_wdata = 32'h12345678;
    mid();
    check1("xw m1_gnt", m1_gnt, 1'b1);
    nxt();
    m1_req = 0; m1_worr = 0;
    m0_req = 1; m0_worr = 0; m0_addr = 5'd31;
    mid();
    check1("xr m0_gnt", m0_gnt, 1'b1);
    check1("xw m1_rvalid G+1", m1_rvalid, 1'b0);
    nxt(); m0_req = 0;
    mid();
    check1("xw m1_rvalid G+2", m1_rvalid, 1'b0);
    check1("xr mem_worr", mem_worr, 1'b0);
    nxt();
    mid();
    check1 ("xr m0_rvalid", m0_rvalid, 1'b1);
    check32("xr m0_rdata", m0_rdata, 32'h12345678);
    check1 ("xr m1_rvalid G+3", m1_rvalid, 1'b0);
    check32("xr m1_rdata holds", m1_rdata, 32'hA1);
    nxt();

    // m1 back-to-back reads of addr 0, 1, 2.
    for (int i = 0; i < 6; i++) begin
      m1_req  = (i < 3);
      m1_worr = 1'b0;
      m1_addr = 5'(i % 3);
      mid();
      if (i < 3) check1("b2b m1_gnt", m1_gnt, 1'b1);
      if (i >= 2 && i < 5) begin
        check1 ("b2b m1_rvalid", m1_rvalid, 1'b1);
        check32("b2b m1_rdata", m1_rdata, 32'hA0 + 32'(i - 2));
      end
      if (i == 5) check1("b2b m1_rvalid end", m1_rvalid, 1'b0);
      nxt();
    end
    m1_req = 0;

    // Idle bus for four cycles.
    for (int i = 0; i < 4; i++) begin
      mid();
      check1 ("idle mem_ena", mem_ena, 1'b0);
      check1 ("idle mem_worr", mem_worr, 1'b0);
      check1 ("idle m0_rvalid", m0_rvalid, 1'b0);
      check1 ("idle m1_rvalid", m1_rvalid, 1'b0);
      check32("idle m0_rdata", m0_rdata, 32'h12345678);
      check32("idle m1_rdata", m1_rdata, 32'hA2);
      nxt();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
